// File: rtl/rng_seed_collector.sv
// Purpose : samples the 32-bit random word bus every SAMPLE_DIV clocks and packs N_WORDS samples into one seed,
//           with a continuous repetition-count health test on every captured sample.
// Latency : seed_valid rises N_WORDS*SAMPLE_DIV edges after IDLE samples enable=1.
// Backpr. : a finished seed is held stable with seed_valid=1 until seed_ready; no sampling happens meanwhile.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              level request for seed collection
//   rng_word[31:0]      random generator output
//   seed_ready          consumer accepts the presented seed
//   clear_fail          acknowledge a health failure (only honoured in FAIL)
//   seed[32*N_WORDS-1:0] assembled seed, sample i in bits [32i+31:32i]
//   seed_valid          seed complete and stable
//   busy                collection in progress
//   health_fail         sticky repetition-test failure
module rng_seed_collector #(
  parameter int N_WORDS    = 4,
  parameter int SAMPLE_DIV = 8,
  parameter int REP_LIMIT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [31:0]            rng_word,
  input  logic                   seed_ready,
  input  logic                   clear_fail,
  output logic [32*N_WORDS-1:0]  seed,
  output logic                   seed_valid,
  output logic                   busy,
  output logic                   health_fail
);

  localparam int DCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WCW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int RCW = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VALID   = 2'd2,
    S_FAIL    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DCW-1:0]         div_cnt_q, div_cnt_d;
  logic [WCW-1:0]         word_cnt_q, word_cnt_d;
  logic [RCW-1:0]         rep_cnt_q, rep_cnt_d;
  logic [31:0]            prev_q, prev_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [32*N_WORDS-1:0]  seed_q, seed_d;

  logic                   sample_edge;
  logic                   rep_trip;
  logic                   last_word;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      word_cnt_q   <= '0;
      rep_cnt_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      seed_q       <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      word_cnt_q   <= word_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      seed_q       <= seed_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    word_cnt_d   = word_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    seed_d       = seed_q;
    sample_edge  = 1'b0;
    rep_trip     = 1'b0;
    last_word    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_COLLECT;
          div_cnt_d  = '0;
          word_cnt_d = '0;
          seed_d     = '0;
        end
      end

      S_COLLECT: begin
        sample_edge = (div_cnt_q == DCW'(SAMPLE_DIV - 1));
        last_word   = (word_cnt_q == WCW'(N_WORDS - 1));
        div_cnt_d   = sample_edge ? '0 : div_cnt_q + DCW'(1);

        // Capture and health test run on the sample edge even if enable
        // drops in the same cycle, so a failure there is never missed.
        if (sample_edge) begin
          for (int i = 0; i < N_WORDS; i++) begin
            if (WCW'(i) == word_cnt_q) begin
              seed_d[32*i +: 32] = rng_word;
            end
          end
          word_cnt_d   = word_cnt_q + WCW'(1);
          rep_cnt_d    = (prev_valid_q && (rng_word == prev_q)) ? rep_cnt_q + RCW'(1) : RCW'(1);
          prev_d       = rng_word;
          prev_valid_d = 1'b1;
          rep_trip     = (rep_cnt_d == RCW'(REP_LIMIT));
        end

        // Failure beats both the enable drop and seed completion.
        if (rep_trip) begin
          state_d = S_FAIL;
          seed_d  = '0;
        end else if (!enable) begin
          state_d = S_IDLE;
          seed_d  = '0;
        end else if (sample_edge && last_word) begin
          state_d = S_VALID;
        end
      end

      S_VALID: begin
        if (seed_ready) begin
          seed_d     = '0;
          div_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = enable ? S_COLLECT : S_IDLE;
        end
      end

      S_FAIL: begin
        if (clear_fail) begin
          state_d      = S_IDLE;
          rep_cnt_d    = '0;
          prev_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state only
  always_comb begin
    seed        = seed_q;
    busy        = (state_q == S_COLLECT);
    seed_valid  = (state_q == S_VALID);
    health_fail = (state_q == S_FAIL);
  end

endmodule

// File: tb/tb_rng_seed_collector.sv
module tb_rng_seed_collector;

  localparam int N_WORDS    = 4;
  localparam int SAMPLE_DIV = 8;
  localparam int REP_LIMIT  = 3;
  localparam int SW         = 32 * N_WORDS;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   rng_word = '0;
  logic          seed_ready = 1'b0;
  logic          clear_fail = 1'b0;
  logic [SW-1:0] seed;
  logic          seed_valid;
  logic          busy;
  logic          health_fail;

  int n_checks = 0;
  int n_pass   = 0;

  rng_seed_collector #(
    .N_WORDS(N_WORDS), .SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rng_word(rng_word),
    .seed_ready(seed_ready), .clear_fail(clear_fail), .seed(seed),
    .seed_valid(seed_valid), .busy(busy), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_COLL, M_VALID, M_FAIL} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_ticks = 0;       // edges since this collection started
  logic [31:0] m_samples[$];      // samples of the seed under construction
  logic [31:0] m_last = '0;
  bit          m_have = 0;
  int          m_run = 0;         // length of current run of identical samples
  int          m_total = 0;       // samples captured overall

  function automatic void model_step(bit r, bit en, bit rd, bit cl, logic [31:0] w);
    bit fail;
    fail = 0;
    if (r) begin
      m_mode = M_IDLE; m_samples.delete(); m_have = 0; m_run = 0; m_ticks = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (en) begin m_mode = M_COLL; m_ticks = 0; m_samples.delete(); end
      M_COLL: begin
        m_ticks++;
        if (m_ticks % SAMPLE_DIV == 0) begin
          m_run = (m_have && w == m_last) ? m_run + 1 : 1;
          m_last = w; m_have = 1; m_total++;
          m_samples.push_back(w);
          fail = (m_run == REP_LIMIT);
        end
        if (fail) begin m_mode = M_FAIL; m_samples.delete(); end
        else if (!en) begin m_mode = M_IDLE; m_samples.delete(); end
        else if (m_samples.size() == N_WORDS) m_mode = M_VALID;
      end
      M_VALID: if (rd) begin
        m_samples.delete(); m_ticks = 0;
        m_mode = en ? M_COLL : M_IDLE;
      end
      M_FAIL: if (cl) begin m_mode = M_IDLE; m_have = 0; m_run = 0; end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  function automatic logic [SW-1:0] m_seed();
    logic [SW-1:0] s;
    s = '0;
    foreach (m_samples[i]) s[32*i +: 32] = m_samples[i];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [SW-1:0] act, logic [SW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock: inputs are captured for the model, outputs compared #1 after the edge.
  task automatic tick();
    bit r, en, rd, cl;
    logic [31:0] w;
    r = rst; en = enable; rd = seed_ready; cl = clear_fail; w = rng_word;
    @(posedge clk);
    model_step(r, en, rd, cl, w);
    #1;
    check("model_busy",  SW'(busy),        SW'(m_mode == M_COLL));
    check("model_valid", SW'(seed_valid),  SW'(m_mode == M_VALID));
    check("model_fail",  SW'(health_fail), SW'(m_mode == M_FAIL));
    check("model_seed",  seed,             m_seed());
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; seed_ready = 1'b0; clear_fail = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- table-driven steps ----------------
  typedef struct {
    int          cycles;
    bit          en;
    bit          rdy;
    bit          clr;
    bit          rnd;
    logic [31:0] word;
    bit          e_busy;
    bit          e_valid;
    bit          e_fail;
  } step_t;

  step_t tbl[$];

  initial begin
    int lat;
    int rises[$];
    bit prev_v;
    int seeds, fails;
    logic [SW-1:0] exp_s;
    logic [31:0] pat[4];

    // Test 1: reset state, 32-edge latency, sample placement, stability
    do_reset();
    check("reset_seed",  seed, '0);
    check("reset_valid", SW'(seed_valid), '0);
    check("reset_busy",  SW'(busy), '0);
    check("reset_fail",  SW'(health_fail), '0);

    enable = 1'b1; rng_word = BASE; lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      tick();
      if (seed_valid) lat = k;
      rng_word = rng_word + 32'd1;
    end
    check("t1_latency", SW'(lat), SW'(32));
    exp_s = {BASE + 32'd32, BASE + 32'd24, BASE + 32'd16, BASE + 32'd8};
    check("t1_seed", seed, exp_s);
    for (int k = 0; k < 20; k++) begin
      tick();
      rng_word = rng_word + 32'd1;
      check("t1_stable", seed, exp_s);
    end

    // Test 2: one-cycle handshake with enable high restarts collection;
    // the new seed lands 32 edges after the handshake edge.
    seed_ready = 1'b1;
    tick();
    rng_word = rng_word + 32'd1;
    seed_ready = 1'b0;
    check("t2_valid_drop", SW'(seed_valid), '0);
    check("t2_busy",       SW'(busy), SW'(1));
    lat = -1;
    for (int k = 1; k < 40 && lat < 0; k++) begin
      tick();
      if (seed_valid) lat = k;
      rng_word = rng_word + 32'd1;
    end
    check("t2_latency", SW'(lat), SW'(32));

    // Throughput with seed_ready tied high: valid rises every N*DIV+1 clocks
    seed_ready = 1'b1; prev_v = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (seed_valid && !prev_v) rises.push_back(k);
      prev_v = seed_valid;
      rng_word = rng_word + 32'd1;
    end
    check("t2_rise_count", SW'(rises.size()), SW'(2));
    if (rises.size() >= 2) check("t2_period", SW'(rises[1] - rises[0]), SW'(33));
    seed_ready = 1'b0;

    // Tests 3 and 5 as tables
    do_reset();
    // stuck bus trips on third sample; sticky; cleared by clear_fail
    tbl.push_back('{1,  1, 0, 0, 0, DB, 1, 0, 0});
    tbl.push_back('{23, 1, 0, 0, 0, DB, 1, 0, 0});
    tbl.push_back('{1,  1, 0, 0, 0, DB, 0, 0, 1});
    tbl.push_back('{10, 1, 0, 0, 0, DB, 0, 0, 1});
    tbl.push_back('{1,  0, 0, 1, 0, DB, 0, 0, 0});
    // partial collection aborted, then a full fresh collection
    tbl.push_back('{1,  1, 0, 0, 1, 0,  1, 0, 0});
    tbl.push_back('{16, 1, 0, 0, 1, 0,  1, 0, 0});
    tbl.push_back('{1,  0, 0, 0, 1, 0,  0, 0, 0});
    tbl.push_back('{1,  1, 0, 0, 1, 0,  1, 0, 0});
    tbl.push_back('{31, 1, 0, 0, 1, 0,  1, 0, 0});
    tbl.push_back('{1,  1, 0, 0, 1, 0,  0, 1, 0});
    foreach (tbl[i]) begin
      enable = tbl[i].en; seed_ready = tbl[i].rdy; clear_fail = tbl[i].clr;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        rng_word = tbl[i].rnd ? $urandom : tbl[i].word;
        tick();
      end
      check($sformatf("tbl%0d_busy", i),  SW'(busy),        SW'(tbl[i].e_busy));
      check($sformatf("tbl%0d_valid", i), SW'(seed_valid),  SW'(tbl[i].e_valid));
      check($sformatf("tbl%0d_fail", i),  SW'(health_fail), SW'(tbl[i].e_fail));
      if (!tbl[i].e_busy && !tbl[i].e_valid)
        check($sformatf("tbl%0d_seed_zero", i), seed, '0);
    end
    clear_fail = 1'b0;

    // Test 4: A,A,B,B,... never reaches REP_LIMIT; seeds keep flowing
    do_reset();
    pat[0] = 32'hAAAA_0001; pat[1] = 32'hAAAA_0001;
    pat[2] = 32'hBBBB_0002; pat[3] = 32'hBBBB_0002;
    m_total = 0; seeds = 0; fails = 0;
    enable = 1'b1; seed_ready = 1'b1;
    for (int k = 0; k < 140; k++) begin
      rng_word = pat[m_total % 4];
      tick();
      if (seed_valid) seeds++;
      if (health_fail) fails++;
    end
    check("t4_seeds", SW'(seeds), SW'(4));
    check("t4_no_fail", SW'(fails), '0);
    seed_ready = 1'b0;

    // Test 6: reset mid-collection and in FAIL
    do_reset();
    enable = 1'b1; rng_word = $urandom;
    for (int k = 0; k < 12; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6a_busy", SW'(busy), '0);
    check("t6a_seed", seed, '0);
    check("t6a_valid", SW'(seed_valid), '0);
    enable = 1'b1; rng_word = DB;
    for (int k = 0; k < 25; k++) tick();
    check("t6b_in_fail", SW'(health_fail), SW'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6b_fail_clr", SW'(health_fail), '0);
    check("t6b_busy", SW'(busy), '0);

    // Randomized traffic against the model, small word alphabet to provoke repeats
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      seed_ready = ($urandom_range(0, 2) == 0);
      clear_fail = ($urandom_range(0, 9) == 0);
      rng_word   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
